// File: rtl/alu_req_sequencer_pkg.sv
// Shared types for the ALU request sequencer: FSM states, flag/response layout, command codes.
package alu_req_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } seq_state_e;

    // Bit order matches the rsp_flags output: {err,oflow,cout,g,l,e}.
    typedef struct packed {
        logic err;
        logic oflow;
        logic cout;
        logic g;
        logic l;
        logic e;
    } alu_flags_t;

    localparam int FLAGS_W = $bits(alu_flags_t);

    // Arithmetic commands (mode=1)
    localparam logic [3:0] CMD_ADD     = 4'd0;
    localparam logic [3:0] CMD_SUB     = 4'd1;
    localparam logic [3:0] CMD_ADD_CIN = 4'd2;
    localparam logic [3:0] CMD_SUB_CIN = 4'd3;
    localparam logic [3:0] CMD_CMP     = 4'd8;
    localparam logic [3:0] CMD_MUL     = 4'd9;
    // Logical commands (mode=0)
    localparam logic [3:0] CMD_AND     = 4'd0;
    localparam logic [3:0] CMD_NAND    = 4'd1;
    localparam logic [3:0] CMD_OR      = 4'd2;
    localparam logic [3:0] CMD_XOR     = 4'd4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO, DEPTH entries (power of 2); head visible combinationally, zero when empty.
// Push and pop on the same edge leave the count unchanged; push while full is dropped unless popping.
module alu_rsp_fifo #(
    parameter int DW    = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_dat_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            pop_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CAP) || do_pop);

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/alu_req_sequencer.sv
// ALU initiator: one op in flight, response ALU_LAT+1 edges after accept, in-order via response FIFO;
// requests stall while busy or FIFO full. Optional error counter under ALU_SEQ_ERRCNT_EN.
module alu_req_sequencer
    import alu_req_sequencer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CMD_W     = 4,
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_opa,
    input  logic [WIDTH-1:0]     req_opb,
    input  logic [CMD_W-1:0]     req_cmd,
    input  logic                 req_mode,
    input  logic                 req_cin,
    input  logic [1:0]           req_inp_valid,
    output logic [WIDTH-1:0]     alu_opa,
    output logic [WIDTH-1:0]     alu_opb,
    output logic [CMD_W-1:0]     alu_cmd,
    output logic                 alu_mode,
    output logic                 alu_cin,
    output logic [1:0]           alu_inp_valid,
    output logic                 alu_ce,
    input  logic [2*WIDTH-1:0]   alu_res,
    input  logic                 alu_cout,
    input  logic                 alu_oflow,
    input  logic                 alu_g,
    input  logic                 alu_l,
    input  logic                 alu_e,
    input  logic                 alu_err,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_res,
    output logic [FLAGS_W-1:0]   rsp_flags
`ifdef ALU_SEQ_ERRCNT_EN
    ,
    output logic [15:0]          err_count
`endif
);
    typedef struct packed {
        logic [2*WIDTH-1:0] res;
        alu_flags_t         flags;
    } rsp_entry_t;

    localparam int CNT_W  = $clog2(ALU_LAT + 1);
    localparam int FCNT_W = $clog2(RSP_DEPTH) + 1;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              mode_q, mode_d, cin_q, cin_d, ce_q, ce_d;
    logic [1:0]        iv_q, iv_d;

    logic              accept, push, pop, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    rsp_entry_t        push_dat, head;

    // The capture slot is reserved at accept time, so count < DEPTH here guarantees the later push fits.
    assign req_ready = rst && (state_q == IDLE) && (fifo_count < FCNT_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        iv_d    = iv_q;
        ce_d    = ce_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d   = req_opa;
                    opb_d   = req_opb;
                    cmd_d   = req_cmd;
                    mode_d  = req_mode;
                    cin_d   = req_cin;
                    iv_d    = req_inp_valid;
                    ce_d    = 1'b1;
                    cnt_d   = CNT_W'(ALU_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    push    = 1'b1;
                    ce_d    = 1'b0;
                    iv_d    = '0;
                    cmd_d   = '0;
                    mode_d  = 1'b0;
                    cin_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            iv_q    <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            iv_q    <= iv_d;
            ce_q    <= ce_d;
        end
    end

    assign alu_opa       = opa_q;
    assign alu_opb       = opb_q;
    assign alu_cmd       = cmd_q;
    assign alu_mode      = mode_q;
    assign alu_cin       = cin_q;
    assign alu_inp_valid = iv_q;
    assign alu_ce        = ce_q;

    assign push_dat = '{res: alu_res,
                        flags: '{err: alu_err, oflow: alu_oflow, cout: alu_cout,
                                 g: alu_g, l: alu_l, e: alu_e}};
    assign pop      = rsp_valid && rsp_ready;

    alu_rsp_fifo #(
        .DW    ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i      (clk),
        .rst_n_i    (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_res   = head.res;
    assign rsp_flags = head.flags;

`ifdef ALU_SEQ_ERRCNT_EN
    logic [15:0] errcnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            errcnt_q <= '0;
        end else if (push && alu_err) begin
            errcnt_q <= sat_inc16(errcnt_q);
        end
    end

    assign err_count = errcnt_q;
`endif

endmodule
